// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit add/sub that reuses one 4-bit lookahead slice per clock, LSB nibble first.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = $clog2(NIB);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_r, b_r, acc;
  logic [IW-1:0] idx;
  logic carry;
  logic [3:0] p, g, s;
  logic c1, c2, c3, gp, gg, cn;
  assign p  = a_r[3:0] ^ b_r[3:0];
  assign g  = a_r[3:0] & b_r[3:0];
  assign c1 = g[0] | (p[0] & carry);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
  assign s  = p ^ {c3, c2, c1, carry};
  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign cn = gg | (gp & carry);
  assign busy = (state == RUN);
  assign done = (state == DONE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= sub ? ~b : b;
          carry <= sub;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          acc   <= {s, acc[WIDTH-1:4]};
          carry <= cn;
          idx   <= idx + 1'b1;
          if (idx == IW'(NIB - 1)) begin
            sum   <= {s, acc[WIDTH-1:4]};
            cout  <= cn;
            ovf   <= cn ^ c3;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: directed checks of timing, arithmetic, start masking and reset abort.
module tb_cla_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy, done, cout, ovf;
  logic [15:0] sum;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cla_nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                        input logic [15:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; a = '0; b = '0; sub = 1'b0;
      chk({tag, " busy"}, busy, 1);
      chk({tag, " no_done"}, done, 0);
    end
    @(negedge clk);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_low"}, busy, 0);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " sum_hold"}, sum, es);
  endtask
  initial begin
    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    chk("rst ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("add", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst sum", sum, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_min", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("sub_zero", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("mixed", 16'hA5C3, 16'h5A3D, 1'b0, 16'h0000, 1'b1, 1'b0);
    // start pulses during RUN and DONE must be dropped
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sb busy1", busy, 1);
    @(negedge clk);
    a = 16'hAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    chk("sb busy4", busy, 1);
    @(negedge clk);
    chk("sb done", done, 1);
    chk("sb sum", sum, 16'h0002);
    a = 16'hAAAA; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sb done_once", done, 0);
    chk("sb idle", busy, 0);
    @(negedge clk);
    chk("sb still_idle", busy, 0);
    chk("sb sum_hold", sum, 16'h0002);
    run_op("after_sb", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);
    // reset in the third RUN cycle aborts without done
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ab busy3", busy, 1);
    rst = 1'b1;
    #1;
    chk("ab busy", busy, 0);
    chk("ab sum", sum, 0);
    chk("ab cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ab no_done", done, 0);
    end
    run_op("post_rst", 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
